// File: rtl/wb_dma_arb_pkg.sv
// rtl/wb_dma_arb_pkg.sv - shared state encodings and field widths for wb_dma_arb
//
// Purpose: common definitions imported by wb_dma_arb and rr_pick.
//   ADDR_W/LEN_W/DATA_W : descriptor and data field widths
//   IDX_W               : width of a channel index (up to 8 channels)
//   state_t             : arbiter FSM encoding
package wb_dma_arb_defs;

   localparam int ADDR_W = 26;
   localparam int LEN_W  = 8;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      BUSY  = 3'd2,
      ZACK  = 3'd3,
      ZDONE = 3'd4
   } state_t;

endpackage

// File: rtl/wb_dma_arb_rr_pick.sv
// rtl/wb_dma_arb_rr_pick.sv - combinational round-robin picker
//
// Purpose: pick the first set bit of eligible, searching upward from
// rr_ptr+1 modulo NCH.
//   eligible : in  NCH  candidate requests
//   rr_ptr   : in  3    last served channel
//   valid    : out 1    at least one candidate
//   win      : out 3    winning channel index
import wb_dma_arb_defs::*;

module rr_pick #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]   eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             valid,
   output logic [IDX_W-1:0] win
);

   logic [3:0] idx;

   // Walk offsets from farthest to nearest so the nearest eligible
   // channel after rr_ptr is the last (and final) assignment.
   always_comb begin
      valid = |eligible;
      win   = '0;
      idx   = '0;
      for (int i = NCH; i >= 1; i--) begin
         idx = {1'b0, rr_ptr} + 4'(i);
         if (idx >= 4'(NCH)) idx = idx - 4'(NCH);
         for (int k = 0; k < NCH; k++) begin
            if (eligible[k] && idx == 4'(k)) win = 3'(k);
         end
      end
   end

endmodule

// File: rtl/wb_dma_arb.sv
// rtl/wb_dma_arb.sv - round-robin multi-channel arbiter in front of the DMA engine
//
// Purpose: grants the single DMA engine to one of NCH requesters, forwards the
// winner's descriptor, routes engine strobes/data to the granted channel and
// completes zero-length requests locally.
//   clk, rst_n                         : clock, async active-low reset
//   cfg_ch_en_i                        : per-channel enable mask
//   ch_req_i/ch_write_i/ch_addr_i/
//   ch_length_i/ch_wdata_i             : per-channel descriptors and write data
//   ch_ack_o/ch_done_o/ch_start_o/
//   ch_wr_o/ch_rd_o/ch_last_o          : per-channel strobes
//   ch_rdata_o                         : read data broadcast
//   dma_req_o/dma_write_o/dma_addr_o/
//   dma_length_o/dma_wdata_o           : descriptor and data to the engine
//   dma_ack_i/dma_done_i/dma_start_i/
//   dma_wr_i/dma_rd_i/dma_last_i/
//   dma_rdata_i                        : strobes and data from the engine
//   busy_o, grant_o                    : status
import wb_dma_arb_defs::*;

module wb_dma_arb #(
   parameter int NCH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        cfg_ch_en_i,
   input  logic [NCH-1:0]        ch_req_i,
   input  logic [NCH-1:0]        ch_write_i,
   input  logic [NCH*ADDR_W-1:0] ch_addr_i,
   input  logic [NCH*LEN_W-1:0]  ch_length_i,
   input  logic [NCH*DATA_W-1:0] ch_wdata_i,
   output logic [NCH-1:0]        ch_ack_o,
   output logic [NCH-1:0]        ch_done_o,
   output logic [NCH-1:0]        ch_start_o,
   output logic [NCH-1:0]        ch_wr_o,
   output logic [NCH-1:0]        ch_rd_o,
   output logic [NCH-1:0]        ch_last_o,
   output logic [DATA_W-1:0]     ch_rdata_o,
   output logic                  dma_req_o,
   output logic                  dma_write_o,
   output logic [ADDR_W-1:0]     dma_addr_o,
   output logic [LEN_W-1:0]      dma_length_o,
   output logic [DATA_W-1:0]     dma_wdata_o,
   input  logic                  dma_ack_i,
   input  logic                  dma_done_i,
   input  logic                  dma_start_i,
   input  logic                  dma_wr_i,
   input  logic                  dma_rd_i,
   input  logic                  dma_last_i,
   input  logic [DATA_W-1:0]     dma_rdata_i,
   output logic                  busy_o,
   output logic [IDX_W-1:0]      grant_o
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant;
   logic [NCH-1:0]     eligible;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_win;
   logic               sel_write;
   logic [ADDR_W-1:0]  sel_addr;
   logic [LEN_W-1:0]   sel_length;
   logic [NCH-1:0]     grant_oh;
   logic               route;
   logic               ack_hit;
   logic               done_hit;

   assign eligible = ch_req_i & cfg_ch_en_i;

   rr_pick #(.NCH(NCH)) u_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .valid    (pick_valid),
      .win      (pick_win)
   );

   // Descriptor of the current round-robin winner.
   always_comb begin
      sel_write  = 1'b0;
      sel_addr   = '0;
      sel_length = '0;
      for (int k = 0; k < NCH; k++) begin
         if (pick_win == 3'(k)) begin
            sel_write  = ch_write_i[k];
            sel_addr   = ch_addr_i[ADDR_W*k +: ADDR_W];
            sel_length = ch_length_i[LEN_W*k +: LEN_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = (sel_length == '0) ? ZACK : REQ;
         REQ:     if (dma_ack_i)  state_nxt = BUSY;
         BUSY:    if (dma_done_i) state_nxt = IDLE;
         ZACK:    state_nxt = ZDONE;
         ZDONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Descriptor and grant are captured only when leaving IDLE so they stay
   // stable while the channel is free to change its inputs after ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= 3'(NCH - 1);
         grant        <= '0;
         dma_req_o    <= 1'b0;
         dma_write_o  <= 1'b0;
         dma_addr_o   <= '0;
         dma_length_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant        <= pick_win;
                  dma_write_o  <= sel_write;
                  dma_addr_o   <= sel_addr;
                  dma_length_o <= sel_length;
                  dma_req_o    <= (sel_length != '0);
               end
            end
            REQ:     if (dma_ack_i) dma_req_o <= 1'b0;
            BUSY:    if (dma_done_i) rr_ptr <= grant;
            ZDONE:   rr_ptr <= grant;
            default: ;
         endcase
      end
   end

   always_comb begin
      grant_oh = '0;
      for (int k = 0; k < NCH; k++) grant_oh[k] = (grant == 3'(k));
   end

   // Routing is already live in REQ: the engine strobes wr and samples
   // write data in its ack cycle.
   assign route    = (state == REQ) || (state == BUSY);
   assign ack_hit  = ((state == REQ) && dma_ack_i) || (state == ZACK);
   assign done_hit = ((state == BUSY) && dma_done_i) || (state == ZDONE);

   assign ch_ack_o   = ack_hit  ? grant_oh : '0;
   assign ch_done_o  = done_hit ? grant_oh : '0;
   assign ch_start_o = (route && dma_start_i) ? grant_oh : '0;
   assign ch_wr_o    = (route && dma_wr_i)    ? grant_oh : '0;
   assign ch_rd_o    = (route && dma_rd_i)    ? grant_oh : '0;
   assign ch_last_o  = (route && dma_last_i)  ? grant_oh : '0;

   always_comb begin
      dma_wdata_o = '0;
      for (int k = 0; k < NCH; k++) begin
         if (grant == 3'(k)) dma_wdata_o = ch_wdata_i[DATA_W*k +: DATA_W];
      end
   end

   assign ch_rdata_o = dma_rdata_i;
   assign busy_o     = (state != IDLE);
   assign grant_o    = grant;

endmodule
